// File: rtl/divider_pipe.sv
// rtl/divider_pipe.sv - fully pipelined restoring divider, signed/unsigned, one op per cycle
module divider_pipe #(
  parameter int N  = 8,
  parameter int M  = 4,
  parameter int TW = 4
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          in_valid,
  output logic          in_ready,
  input  logic          in_signed,
  input  logic [N-1:0]  dividend,
  input  logic [M-1:0]  divisor,
  input  logic [TW-1:0] in_tag,
  output logic          out_valid,
  input  logic          out_ready,
  output logic [N-1:0]  quotient,
  output logic [M-1:0]  remainder,
  output logic [TW-1:0] out_tag,
  output logic          div_zero,
  output logic          ovf,
  output logic          busy
);

  localparam logic [N-1:0] MOST_NEG = {1'b1, {(N-1){1'b0}}};

  logic stall;
  assign stall    = out_valid & ~out_ready;
  assign in_ready = ~stall;

  // Per-stage control bits, bit k belongs to stage k (0..N)
  logic [N:0] vld, sgn, sa, sb, dz, ov;

  logic [TW-1:0] tg [0:N];
  logic [N-1:0]  wk [0:N];
  logic [M-1:0]  rm [0:N];
  logic [M-1:0]  dv [0:N-1];

  logic          neg_a, neg_b, zero_b, ovf_in;
  logic [N-1:0]  mag_a;
  logic [M-1:0]  mag_b;

  assign neg_a  = in_signed & dividend[N-1];
  assign neg_b  = in_signed & divisor[M-1];
  assign mag_a  = neg_a ? -dividend : dividend;
  assign mag_b  = neg_b ? -divisor : divisor;
  assign zero_b = (divisor == '0);
  assign ovf_in = in_signed & (dividend == MOST_NEG) & (divisor == '1);

  logic [N-1:0] nwk [1:N];
  logic [M-1:0] nrm [1:N];

  // wk shifts the dividend out of the top while quotient bits enter at the bottom
  for (genvar k = 1; k <= N; k++) begin : g_step
    logic [M:0]   sh;
    logic [M-1:0] df;
    logic         ge;
    assign sh     = {rm[k-1], wk[k-1][N-1]};
    assign ge     = (sh >= {1'b0, dv[k-1]});
    assign df     = sh[M-1:0] - dv[k-1];
    assign nrm[k] = ge ? df : sh[M-1:0];
    assign nwk[k] = {wk[k-1][N-2:0], ge};
  end

  logic          neg_q, neg_r;
  logic [N-1:0]  fin_q;
  logic [M-1:0]  fin_r;

  assign neg_q = sgn[N] & (sa[N] ^ sb[N]);
  assign neg_r = sgn[N] & sa[N];

  always_comb begin
    fin_q = neg_q ? -wk[N] : wk[N];
    fin_r = neg_r ? -rm[N] : rm[N];
    if (dz[N]) begin
      fin_q = '1;
      fin_r = '0;
    end else if (ov[N]) begin
      fin_q = MOST_NEG;
      fin_r = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vld       <= '0;
      out_valid <= 1'b0;
      quotient  <= '0;
      remainder <= '0;
      out_tag   <= '0;
      div_zero  <= 1'b0;
      ovf       <= 1'b0;
    end else if (!stall) begin
      vld       <= {vld[N-1:0], in_valid};
      sgn       <= {sgn[N-1:0], in_signed};
      sa        <= {sa[N-1:0], neg_a};
      sb        <= {sb[N-1:0], neg_b};
      dz        <= {dz[N-1:0], zero_b};
      ov        <= {ov[N-1:0], ovf_in};
      out_valid <= vld[N];
      // Bubbles leave the last result on the outputs rather than loading stale data
      if (vld[N]) begin
        quotient  <= fin_q;
        remainder <= fin_r;
        out_tag   <= tg[N];
        div_zero  <= dz[N];
        ovf       <= ov[N];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!stall) begin
      tg[0] <= in_tag;
      wk[0] <= mag_a;
      rm[0] <= '0;
      dv[0] <= mag_b;
      for (int k = 1; k <= N; k++) begin
        tg[k] <= tg[k-1];
        wk[k] <= nwk[k];
        rm[k] <= nrm[k];
      end
      for (int k = 1; k < N; k++) begin
        dv[k] <= dv[k-1];
      end
    end
  end

  assign busy = (|vld) | out_valid;

endmodule

// File: tb/tb_divider_pipe.sv
// tb/tb_divider_pipe.sv - self-checking bench for divider_pipe
module tb_divider_pipe;

  localparam int N  = 8;
  localparam int M  = 4;
  localparam int TW = 4;

  logic          clk = 1'b0;
  logic          reset = 1'b1;
  logic          in_valid = 1'b0;
  logic          in_signed = 1'b0;
  logic [N-1:0]  dividend = '0;
  logic [M-1:0]  divisor = '0;
  logic [TW-1:0] in_tag = '0;
  logic          out_ready = 1'b1;
  logic          in_ready, out_valid, div_zero, ovf, busy;
  logic [N-1:0]  quotient;
  logic [M-1:0]  remainder;
  logic [TW-1:0] out_tag;

  divider_pipe #(.N(N), .M(M), .TW(TW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_signed(in_signed), .dividend(dividend), .divisor(divisor), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready), .quotient(quotient),
    .remainder(remainder), .out_tag(out_tag), .div_zero(div_zero), .ovf(ovf),
    .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [N-1:0]  q;
    logic [M-1:0]  r;
    logic [TW-1:0] tag;
    logic          dz;
    logic          ov;
  } exp_t;

  typedef struct {
    logic         s;
    logic [N-1:0] a;
    logic [M-1:0] b;
    logic [N-1:0] q;
    logic [M-1:0] r;
    logic         dz;
    logic         ov;
  } vec_t;

  exp_t exp_q[$];
  vec_t vecs[16];
  int   tests = 0;
  int   fails = 0;
  int   rx = 0;
  bit   rand_done = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    tests++;
    if (act !== expv) begin
      fails++;
      $display("FAIL %s: got %0h, required %0h", name, act, expv);
    end
  endtask

  task automatic fail_now(input string name);
    tests++;
    fails++;
    $display("FAIL %s", name);
  endtask

  // Reference: plain integer arithmetic on the operand values
  function automatic exp_t model(input logic s, input logic [N-1:0] a,
                                 input logic [M-1:0] b, input logic [TW-1:0] t);
    exp_t e;
    int ai, bi, qi, ri;
    e.tag = t;
    e.dz  = 1'b0;
    e.ov  = 1'b0;
    if (b == 0) begin
      e.q  = '1;
      e.r  = '0;
      e.dz = 1'b1;
    end else begin
      ai = s && a[N-1] ? int'(a) - (1 << N) : int'(a);
      bi = s && b[M-1] ? int'(b) - (1 << M) : int'(b);
      qi = ai / bi;
      ri = ai % bi;
      if (s && ai == -(1 << (N-1)) && bi == -1) e.ov = 1'b1;
      e.q = qi[N-1:0];
      e.r = ri[M-1:0];
    end
    return e;
  endfunction

  function automatic logic [N-1:0] pick_a();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return N'(1);
      2: return '1;
      3: return {1'b1, {(N-1){1'b0}}};
      default: return N'($urandom);
    endcase
  endfunction

  function automatic logic [M-1:0] pick_b();
    case ($urandom_range(0, 7))
      0: return '0;
      1: return M'(1);
      2: return '1;
      3: return {1'b1, {(M-1){1'b0}}};
      default: return M'($urandom);
    endcase
  endfunction

  // Call at posedge+1; returns at posedge+1 after the transfer edge
  task automatic send(input logic s, input logic [N-1:0] a, input logic [M-1:0] b,
                      input logic [TW-1:0] t, input exp_t e);
    int guard;
    guard = 0;
    in_valid  = 1'b1;
    in_signed = s;
    dividend  = a;
    divisor   = b;
    in_tag    = t;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      guard++;
      if (guard > 100) begin
        fail_now("in_ready_timeout");
        break;
      end
    end
    @(posedge clk);
    exp_q.push_back(e);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic drain();
    for (int c = 0; c < 300 && exp_q.size() != 0; c++) @(negedge clk);
    chk("drain_empty", exp_q.size(), 0);
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    exp_t got, e;
    if (!reset && out_valid && out_ready) begin
      got = {quotient, remainder, out_tag, div_zero, ovf};
      rx++;
      if (exp_q.size() == 0) begin
        fail_now($sformatf("unexpected_result q=%0h r=%0h tag=%0h", quotient, remainder, out_tag));
      end else begin
        e = exp_q.pop_front();
        chk($sformatf("result_tag%0d", e.tag), 32'(got), 32'(e));
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    int   lat, start_rx, stale;
    exp_t e;
    logic [31:0] snap;

    vecs[0]  = '{1'b0, 8'd200, 4'd7, 8'd28, 4'd4, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 8'h9C, 4'h7, 8'hF2, 4'hE, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 8'h64, 4'h9, 8'hF2, 4'h2, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 8'h55, 4'h0, 8'hFF, 4'h0, 1'b1, 1'b0};
    vecs[4]  = '{1'b1, 8'h55, 4'h0, 8'hFF, 4'h0, 1'b1, 1'b0};
    vecs[5]  = '{1'b1, 8'h80, 4'hF, 8'h80, 4'h0, 1'b0, 1'b1};
    vecs[6]  = '{1'b0, 8'h80, 4'hF, 8'h08, 4'h8, 1'b0, 1'b0};
    vecs[7]  = '{1'b0, 8'hFF, 4'h1, 8'hFF, 4'h0, 1'b0, 1'b0};
    vecs[8]  = '{1'b0, 8'hFF, 4'hF, 8'h11, 4'h0, 1'b0, 1'b0};
    vecs[9]  = '{1'b1, 8'hFF, 4'hF, 8'h01, 4'h0, 1'b0, 1'b0};
    vecs[10] = '{1'b1, 8'h80, 4'h1, 8'h80, 4'h0, 1'b0, 1'b0};
    vecs[11] = '{1'b1, 8'h7F, 4'h8, 8'hF1, 4'h7, 1'b0, 1'b0};
    vecs[12] = '{1'b1, 8'h81, 4'h7, 8'hEE, 4'hF, 1'b0, 1'b0};
    vecs[13] = '{1'b0, 8'h00, 4'h5, 8'h00, 4'h0, 1'b0, 1'b0};
    vecs[14] = '{1'b0, 8'h03, 4'h9, 8'h00, 4'h3, 1'b0, 1'b0};
    vecs[15] = '{1'b1, 8'h80, 4'h8, 8'h10, 4'h0, 1'b0, 1'b0};

    repeat (2) @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    chk("rst_quotient", quotient, 0);
    chk("rst_remainder", remainder, 0);
    chk("rst_out_tag", out_tag, 0);
    chk("rst_div_zero", div_zero, 0);
    chk("rst_ovf", ovf, 0);

    // 200/7 latency and value
    @(posedge clk);
    #1;
    e = '{8'd28, 4'd4, 4'd9, 1'b0, 1'b0};
    send(1'b0, 8'd200, 4'd7, 4'd9, e);
    lat = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      if (out_valid) begin
        lat = c;
        break;
      end
    end
    chk("latency", lat, N + 2);
    drain();

    for (int i = 0; i < 16; i++) begin
      e = '{vecs[i].q, vecs[i].r, TW'(i), vecs[i].dz, vecs[i].ov};
      send(vecs[i].s, vecs[i].a, vecs[i].b, TW'(i), e);
    end
    drain();

    // 12 back-to-back with a 5-cycle output stall
    start_rx = rx;
    fork
      begin
        for (int i = 0; i < 12; i++) begin
          logic s;
          logic [N-1:0] a;
          logic [M-1:0] b;
          s = 1'($urandom);
          a = pick_a();
          b = pick_b();
          send(s, a, b, TW'(i), model(s, a, b, TW'(i)));
        end
      end
      begin
        for (int c = 0; c < 100; c++) begin
          @(negedge clk);
          if (out_valid) break;
        end
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        snap = 32'({quotient, remainder, out_tag, div_zero, ovf});
        for (int c = 0; c < 5; c++) begin
          @(negedge clk);
          chk("stall_in_ready", in_ready, 0);
          chk("stall_out_valid", out_valid, 1);
          chk("stall_stable", 32'({quotient, remainder, out_tag, div_zero, ovf}), snap);
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
      end
    join
    drain();
    chk("stall_count", rx - start_rx, 12);

    // Reset with four operations in flight, plus an input offered during reset
    for (int i = 0; i < 4; i++) begin
      send(1'b0, 8'd100 + 8'(i), 4'd3, TW'(i), model(1'b0, 8'd100 + 8'(i), 4'd3, TW'(i)));
    end
    reset     = 1'b1;
    in_valid  = 1'b1;
    dividend  = 8'd77;
    divisor   = 4'd5;
    in_tag    = 4'd15;
    @(negedge clk);
    chk("busy_inflight", busy, 1);
    @(posedge clk);
    #1;
    reset    = 1'b0;
    in_valid = 1'b0;
    exp_q.delete();
    @(negedge clk);
    chk("flush_out_valid", out_valid, 0);
    chk("flush_busy", busy, 0);
    chk("flush_in_ready", in_ready, 1);
    stale = 0;
    for (int c = 0; c < 3 * N; c++) begin
      @(negedge clk);
      if (out_valid || busy) stale++;
    end
    chk("no_stale", stale, 0);
    @(posedge clk);
    #1;

    // Random mixed sweep with random backpressure
    fork
      begin
        for (int i = 0; i < 300; i++) begin
          logic s;
          logic [N-1:0] a;
          logic [M-1:0] b;
          logic [TW-1:0] t;
          s = 1'($urandom);
          a = pick_a();
          b = pick_b();
          t = TW'($urandom);
          send(s, a, b, t, model(s, a, b, t));
        end
        rand_done = 1;
      end
      begin
        while (!rand_done) begin
          @(posedge clk);
          #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/divider_pipe.md
DIVIDER_PIPE -- requirements
Module: divider_pipe

Interface
REQ-001 The block SHALL have parameter N, default 8: dividend and quotient width in bits (N >= 2).
REQ-002 The block SHALL have parameter M, default 4: divisor and remainder width in bits (2 <= M <= N).
REQ-003 The block SHALL have parameter TW, default 4: width of the sideband tag carried with each operation.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all logic is on the rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: synchronous, active-high reset.
REQ-006 The block SHALL have port in_valid, input, 1 bit: operands are presented.
REQ-007 The block SHALL have port in_ready, output, 1 bit: the block accepts operands this cycle.
REQ-008 The block SHALL have port in_signed, input, 1 bit: 1 = two's-complement operation, 0 = unsigned operation.
REQ-009 The block SHALL have port dividend, input, N bits: the dividend.
REQ-010 The block SHALL have port divisor, input, M bits: the divisor.
REQ-011 The block SHALL have port in_tag, input, TW bits: opaque tag returned with the result.
REQ-012 The block SHALL have port out_valid, output, 1 bit: a result is presented.
REQ-013 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the result.
REQ-014 The block SHALL have port quotient, output, N bits: the quotient.
REQ-015 The block SHALL have port remainder, output, M bits: the remainder.
REQ-016 The block SHALL have port out_tag, output, TW bits: in_tag of this result.
REQ-017 The block SHALL have port div_zero, output, 1 bit: the divisor was 0.
REQ-018 The block SHALL have port ovf, output, 1 bit: signed overflow (most-negative dividend divided by -1).
REQ-019 The block SHALL have port busy, output, 1 bit: at least one pipeline stage holds a valid operation.

Function
REQ-020 A transfer SHALL occur on an input cycle with in_valid=1 and in_ready=1, and on an output cycle with out_valid=1 and out_ready=1.
REQ-021 The pipeline SHALL have N+2 stages: stage 0 takes operand magnitudes and signs, stages 1..N each resolve one quotient bit MSB-first by restoring subtract, and stage N+1 applies the sign fixup and flags.
REQ-022 Every stage SHALL carry a valid bit, in_signed, the operand signs, the tag, div_zero and ovf.
REQ-023 Latency SHALL be exactly N+2 cycles from input transfer to out_valid when there is no stall.
REQ-024 Throughput SHALL be one operation per cycle.
REQ-025 stall SHALL equal out_valid AND NOT out_ready.
REQ-026 While stall=1, all stages SHALL hold their contents.
REQ-027 in_ready SHALL equal NOT stall (combinational).
REQ-028 A bubble SHALL NOT be collapsed: stages advance together.
REQ-029 While stall=1, quotient, remainder, out_tag, div_zero and ovf SHALL remain stable.
REQ-030 Unsigned mode: quotient = floor(dividend/divisor) and remainder = dividend mod divisor, where remainder < divisor always fits M bits.
REQ-031 Signed mode: the quotient SHALL truncate toward zero, the remainder SHALL take the sign of the dividend, and dividend = quotient*divisor + remainder SHALL hold.
REQ-032 Divisor = 0, either mode: quotient = all ones, remainder = 0, div_zero=1, ovf=0.
REQ-033 Signed mode with dividend = -2^(N-1) and divisor = -1: quotient = -2^(N-1), remainder = 0, ovf=1, div_zero=0.
REQ-034 The divide-by-zero and overflow flags SHALL be decided in stage 0 and travel with the operation.
REQ-035 Each operation SHALL use its own in_signed value, so unsigned and signed operations may be mixed back-to-back.
REQ-036 Dividend magnitude for -2^(N-1) SHALL be represented in N bits without loss (unsigned 2^(N-1)).
REQ-037 busy SHALL be the OR of all stage valid bits.
REQ-038 out_valid SHALL be the valid bit of stage N+1.

Reset
REQ-039 While reset=1 at a clock edge, all stage valid bits SHALL clear, so out_valid=0, busy=0 and in_ready=1 from the following cycle.
REQ-040 After reset, quotient, remainder, out_tag, div_zero and ovf SHALL be 0.
REQ-041 An operation in flight when reset is asserted SHALL be discarded and never appear at the output.
REQ-042 An input presented in a cycle with reset=1 SHALL NOT be accepted.

Verification
REQ-043 The bench SHALL check (N=8, M=4) unsigned 200/7 -> after 10 cycles quotient=28, remainder=4, flags 0, out_tag echoed.
REQ-044 The bench SHALL check signed -100 (0x9C) / 7 -> quotient=0xF2 (-14), remainder=0xE (-2); and signed 100 / -7 -> quotient=0xF2, remainder=0x2.
REQ-045 The bench SHALL check divisor=0 with dividend=0x55 -> quotient=0xFF, remainder=0, div_zero=1; and signed 0x80 / 0xF -> quotient=0x80, remainder=0, ovf=1.
REQ-046 The bench SHALL check 12 back-to-back operations with out_ready held 0 for 5 cycles once the first result appears -> in_ready=0 during the stall, outputs stable, all 12 results delivered in order with no loss or duplication.
REQ-047 The bench SHALL check reset asserted with 4 operations in flight -> out_valid=0 and busy=0 on the next cycle, and no stale result thereafter.
REQ-048 The bench SHALL run a random mixed signed/unsigned sweep against a reference model, including extremes 0, 1, max, -1 and most-negative.
